data_decoder: RTL

Receive-side Maple bus line decoder. It samples the two bus lines SDCKA/SDCKB and detects the start pattern. It then recovers data bits MSB-first and pushes each completed byte into the slave RX FIFO. Detecting the end pattern closes the frame. It is the wire-side counterpart of the transmit encoder and shares its idle-high, two-phase bit convention.

---
 rtl/maple_pkg.sv | 18 +
 rtl/maple_line_sync.sv | 30 +++
 rtl/data_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: one-hot decoder state encoding and frame constants.
package maple_pkg;

  localparam int START_PULSES = 4;
  localparam int BYTE_BITS    = 8;
  localparam int BIT_CNT_W    = $clog2(BYTE_BITS + 1);
  localparam int PULSE_CNT_W  = $clog2(START_PULSES + 1);

  typedef enum logic [5:0] {
    IDLE        = 6'b000001,
    START_COUNT = 6'b000010,
    PHASE1      = 6'b000100,
    PHASE2      = 6'b001000,
    END_WAIT    = 6'b010000,
    DONE        = 6'b100000
  } state_t;

endpackage

// File: rtl/maple_line_sync.sv
// Two-flop synchronizer plus previous-value register for one Maple bus line.
// Resets to 1 so an idle-high bus produces no spurious edges out of reset.
module maple_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic sync,
  output logic fall,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;
  assign rise = ~prev & sync;

endmodule

// File: rtl/data_decoder.sv
// Maple bus receive decoder: start/end pattern detection and MSB-first byte recovery.
// Define DATA_DECODER_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES clocks without a line edge.
module data_decoder
  import maple_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sdcka,
  input  logic                 sdckb,
  input  logic                 full,
  output logic [BYTE_BITS-1:0] data,
  output logic                 write,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  logic a_sync, a_fall, a_rise;
  logic b_sync, b_fall, b_rise;
  logic a_edge, b_edge;
  logic timeout;

  state_t                 state, state_nxt;
  logic [PULSE_CNT_W-1:0] pulse_cnt, pulse_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
  logic [BYTE_BITS-1:0]   shreg, shreg_nxt;
  logic [BYTE_BITS-1:0]   data_nxt;
  logic                   b_rose, b_rose_nxt;
  logic                   write_nxt, error_nxt;
  logic                   shift_en, shift_bit, abort;

  maple_line_sync u_sync_a (
    .clk   (clk),
    .reset (reset),
    .line  (sdcka),
    .sync  (a_sync),
    .fall  (a_fall),
    .rise  (a_rise)
  );

  maple_line_sync u_sync_b (
    .clk   (clk),
    .reset (reset),
    .line  (sdckb),
    .sync  (b_sync),
    .fall  (b_fall),
    .rise  (b_rise)
  );

  assign a_edge = a_fall | a_rise;
  assign b_edge = b_fall | b_rise;

`ifdef DATA_DECODER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] quiet_cnt;

  // Counts clocks since the last line edge while a frame is open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quiet_cnt <= '0;
    end else if (state == IDLE || a_edge || b_edge) begin
      quiet_cnt <= '0;
    end else if (!timeout) begin
      quiet_cnt <= quiet_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (quiet_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      b_rose    <= 1'b0;
      data      <= '0;
      write     <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      b_rose    <= b_rose_nxt;
      data      <= data_nxt;
      write     <= write_nxt;
      error     <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pulse_nxt  = pulse_cnt;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    b_rose_nxt = b_rose;
    data_nxt   = data;
    write_nxt  = 1'b0;
    error_nxt  = 1'b0;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    abort      = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
    end else if (state != IDLE && ((a_edge && b_edge) || timeout)) begin
      abort = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a_fall && b_sync) begin
            state_nxt = START_COUNT;
            pulse_nxt = '0;
          end
        end
        START_COUNT: begin
          if (b_fall) begin
            if (pulse_cnt == PULSE_CNT_W'(START_PULSES)) abort = 1'b1;
            else pulse_nxt = pulse_cnt + 1'b1;
          end else if (a_rise) begin
            if (pulse_cnt == PULSE_CNT_W'(START_PULSES)) state_nxt = PHASE1;
            else abort = 1'b1;
          end
        end
        PHASE1: begin
          if (a_fall) begin
            shift_en   = 1'b1;
            shift_bit  = b_sync;
            b_rose_nxt = 1'b0;
            state_nxt  = PHASE2;
          end
        end
        PHASE2: begin
          // An A fall with B held low is the end marker; its lone provisional bit is dropped.
          if (b_rise) begin
            b_rose_nxt = 1'b1;
          end else if (b_fall) begin
            shift_en  = 1'b1;
            shift_bit = a_sync;
            state_nxt = PHASE1;
          end else if (a_fall && !b_rose) begin
            if (bit_cnt == BIT_CNT_W'(1)) state_nxt = END_WAIT;
            else abort = 1'b1;
          end
        end
        END_WAIT: begin
          if (b_rise) state_nxt = DONE;
          else if (a_fall) abort = 1'b1;
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    if (shift_en) begin
      shreg_nxt = {shreg[BYTE_BITS-2:0], shift_bit};
      if (bit_cnt == BIT_CNT_W'(BYTE_BITS - 1)) begin
        bit_nxt = '0;
        if (full) begin
          abort = 1'b1;
        end else begin
          write_nxt = 1'b1;
          data_nxt  = shreg_nxt;
        end
      end else begin
        bit_nxt = bit_cnt + 1'b1;
      end
    end

    if (abort) begin
      error_nxt = 1'b1;
      state_nxt = IDLE;
    end

    if (state_nxt == IDLE) begin
      pulse_nxt  = '0;
      bit_nxt    = '0;
      shreg_nxt  = '0;
      b_rose_nxt = 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
